// File: rtl/pueo_trig_capture_if.sv
// Event hand-off bus from the trigger capture block to the event builder.
// The master drives valid and the event fields; the slave answers with ready.
interface pueo_trig_capture_if #(
  parameter int unsigned TS_W = 48
);
  logic            evt_valid;
  logic            evt_ready;
  logic [31:0]     evt_num;
  logic [TS_W-1:0] evt_time;
  logic [255:0]    evt_meta;

  modport master (output evt_valid, evt_num, evt_time, evt_meta, input evt_ready);
  modport slave  (input evt_valid, evt_num, evt_time, evt_meta, output evt_ready);
endinterface

// File: rtl/pueo_trig_capture.sv
// pueo_trig_capture: accepts level-two master triggers, stamps each with an
// event number and timestamp, and queues {num, time, meta} in a first-word
// fall-through FIFO for the event builder. Drives holdoff/dead back to level two.
// Optional: define PUEO_TRIG_CAPTURE_DEADTIME_EN to add the deadtime_o counter.
module pueo_trig_capture #(
  parameter int unsigned HOLDOFF_LEN = 16,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned TS_W        = 48
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ce_i,
  input  logic        run_i,
  input  logic        trig_i,
  input  logic [63:0] tio0_meta_i,
  input  logic [63:0] tio1_meta_i,
  input  logic [63:0] tio2_meta_i,
  input  logic [63:0] tio3_meta_i,
  output logic        holdoff_o,
  output logic        dead_o,
  output logic        drop_o,
`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
  output logic [31:0] deadtime_o,
`endif
  pueo_trig_capture_if.master evt
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned EW    = 32 + TS_W + 256;
  // one slot is kept back for a trigger already in flight in level two
  localparam logic [FIFO_AW:0] DEAD_LVL = (FIFO_AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} state_t;

  state_t             state_q, state_d;
  logic               run_q;
  logic               holdoff_q, holdoff_d;
  logic               dead_q, dead_d;
  logic               drop_q, drop_d;
  logic [15:0]        hcnt_q, hcnt_d;
  logic [31:0]        num_q, num_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [EW-1:0]      mem_q [DEPTH];
  logic               run_rise, push, pop;

  assign run_rise = run_i & ~run_q;
  // a trigger seen while ARMED is pushed only if the FIFO still has room
  assign push     = (state_q == ARMED) && trig_i && !dead_q;
  assign pop      = (cnt_q != '0) && evt.evt_ready;

  // next state and holdoff countdown; run_i low overrides everything
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    if (!run_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run_rise) state_d = ARMED;
        ARMED:   if (trig_i) begin
                   state_d = HOLDOFF;
                   hcnt_d  = 16'(HOLDOFF_LEN);
                 end
        HOLDOFF: if (ce_i) begin
                   hcnt_d = hcnt_q - 16'd1;
                   if (hcnt_q <= 16'd1) state_d = ARMED;
                 end
        default: state_d = IDLE;
      endcase
    end
    holdoff_d = (state_d != ARMED);
  end

  // event number, timestamp and sticky drop flag
  always_comb begin
    num_d  = num_q;
    ts_d   = ts_q;
    drop_d = drop_q;
    if (run_rise) begin
      num_d  = '0;
      ts_d   = '0;
      drop_d = 1'b0;
    end else begin
      if (push) num_d = num_q + 32'd1;
      if (ce_i && (state_q != IDLE)) ts_d = ts_q + TS_W'(1);
      if (trig_i && (holdoff_q || dead_q)) drop_d = 1'b1;
    end
  end

  // FIFO pointers, occupancy and the registered dead flag
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + FIFO_AW'(1);
    if (pop)  rd_d = rd_q + FIFO_AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (FIFO_AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    dead_d = (cnt_d >= DEAD_LVL);
  end

  // state and counter registers; reset flushes the FIFO via its pointers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      run_q     <= 1'b0;
      holdoff_q <= 1'b1;
      dead_q    <= 1'b0;
      drop_q    <= 1'b0;
      hcnt_q    <= '0;
      num_q     <= '0;
      ts_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_i;
      holdoff_q <= holdoff_d;
      dead_q    <= dead_d;
      drop_q    <= drop_d;
      hcnt_q    <= hcnt_d;
      num_q     <= num_d;
      ts_q      <= ts_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage; no reset needed since the pointers define validity
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {num_q, ts_q, tio3_meta_i, tio2_meta_i, tio1_meta_i, tio0_meta_i};
  end

  assign holdoff_o     = holdoff_q;
  assign dead_o        = dead_q;
  assign drop_o        = drop_q;
  assign evt.evt_valid = (cnt_q != '0);
  assign {evt.evt_num, evt.evt_time, evt.evt_meta} = mem_q[rd_q];

`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
  logic [31:0] dt_q, dt_d;

  // ce cycles spent blocked (holdoff or dead) during a run, saturating
  always_comb begin
    dt_d = dt_q;
    if (run_rise) dt_d = '0;
    else if (ce_i && (state_q != IDLE) && (holdoff_q || dead_q) && (dt_q != 32'hFFFF_FFFF))
      dt_d = dt_q + 32'd1;
  end

  // deadtime register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) dt_q <= '0;
    else          dt_q <= dt_d;
  end

  assign deadtime_o = dt_q;
`else
  // deadtime accounting is not built in this configuration
`endif
endmodule

// File: tb/tb_pueo_trig_capture.sv
// Bench for pueo_trig_capture: a vector table for reset/run start-up, hand
// sequences for holdoff, back-pressure, push/pop at occupancy 14, run drop and
// reset, then random traffic checked every cycle against a queue-based model.
module tb_pueo_trig_capture;
  localparam int DEPTH = 16;
  localparam int HL    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, ce = 1'b0, run = 1'b0, trig = 1'b0, ready = 1'b0;
  logic [63:0] m0 = 64'h0123_4567_89AB_CDEF, m1 = '0, m2 = '0, m3 = '0;
  logic        holdoff_o, dead_o, drop_o;
`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
  logic [31:0] deadtime_o;
`endif

  int total = 0, bad = 0;
  bit mchk_en = 1'b0, ce_auto = 1'b0;

  pueo_trig_capture_if #(.TS_W(48)) evt_if ();
  assign evt_if.evt_ready = ready;

  pueo_trig_capture #(.HOLDOFF_LEN(HL), .FIFO_AW(4), .TS_W(48)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .run_i(run), .trig_i(trig),
    .tio0_meta_i(m0), .tio1_meta_i(m1), .tio2_meta_i(m2), .tio3_meta_i(m3),
    .holdoff_o(holdoff_o), .dead_o(dead_o), .drop_o(drop_o),
`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
    .deadtime_o(deadtime_o),
`endif
    .evt(evt_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  // ---------------- reference model: run flag, holdoff ce budget, event queue
  typedef struct packed {
    logic [31:0]  num;
    logic [47:0]  tm;
    logic [255:0] meta;
  } ev_t;

  ev_t         mq[$];
  bit          m_act, m_prun, m_drop;
  int          m_hold;
  logic [31:0] m_num, m_dt;
  logic [47:0] m_ts;
  bit          m_rise, m_armed, m_hvis, m_dvis, m_psh, m_pp;
  ev_t         m_ev;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_act = 0; m_prun = 0; m_drop = 0; m_hold = 0;
      m_num = '0; m_ts = '0; m_dt = '0;
    end else begin
      m_rise  = run && !m_prun;
      m_armed = m_act && (m_hold == 0);
      m_hvis  = !m_armed;
      m_dvis  = (mq.size() >= DEPTH - 1);
      m_psh   = m_armed && trig && !m_dvis;
      m_pp    = (mq.size() != 0) && ready;
      if (m_rise) m_dt = '0;
      else if (ce && m_act && (m_hvis || m_dvis) && m_dt != 32'hFFFF_FFFF) m_dt = m_dt + 1;
      if (m_pp) void'(mq.pop_front());
      if (m_psh) begin
        m_ev = {m_num, m_ts, m3, m2, m1, m0};
        mq.push_back(m_ev);
      end
      if (m_rise) m_drop = 0;
      else if (trig && (m_hvis || m_dvis)) m_drop = 1;
      if (m_rise) m_num = '0;
      else if (m_psh) m_num = m_num + 1;
      if (m_rise) m_ts = '0;
      else if (ce && m_act) m_ts = m_ts + 1;
      if (!run) begin
        m_act = 0; m_hold = 0;
      end else if (!m_act) begin
        if (m_rise) begin m_act = 1; m_hold = 0; end
      end else if (m_armed) begin
        if (trig) m_hold = HL;
      end else if (ce) begin
        m_hold = m_hold - 1;
      end
      m_prun = run;
    end
  end

  // every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (mchk_en) begin
      chk("m_holdoff", holdoff_o, !(m_act && m_hold == 0));
      chk("m_dead", dead_o, mq.size() >= DEPTH - 1);
      chk("m_drop", drop_o, m_drop);
      chk("m_valid", evt_if.evt_valid, mq.size() != 0);
      if (mq.size() != 0 && evt_if.evt_valid) begin
        chk("m_num", evt_if.evt_num, mq[0].num);
        chk("m_time", evt_if.evt_time, mq[0].tm);
        chk("m_meta", evt_if.evt_meta, mq[0].meta);
      end
`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
      chk("m_deadtime", deadtime_o, m_dt);
`endif
    end
  end

  // ---------------- helpers
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (ce_auto) ce = ~ce;
  endtask

  task automatic wait_armed();
    int g;
    g = 0;
    while (holdoff_o && g < 400) begin tick(); g++; end
    chk("wait_armed", holdoff_o, 1'b0);
  endtask

  task automatic restart_run();
    run = 1'b0; tick(); tick();
    run = 1'b1; tick();
    chk("restart_hold", holdoff_o, 1'b0);
    chk("restart_drop", drop_o, 1'b0);
  endtask

  task automatic drain(input int first, input int n, input bit dchk);
    int idx;
    bit done;
    idx = 0; done = 0; ready = 1'b1;
    for (int g = 0; g < n + 20; g++) begin
      if (evt_if.evt_valid) begin
        chk("drain_num", evt_if.evt_num, first + idx);
        idx++;
      end
      tick();
      if (dchk && idx == 1 && !done) begin
        chk("dead_after_pop", dead_o, 1'b0);
        done = 1;
      end
    end
    ready = 1'b0;
    chk("drain_count", idx, n);
  endtask

  typedef struct {
    logic        rst_n, run, ce, trig;
    logic        e_hold, e_valid, e_dead, e_drop;
    logic [47:0] e_tm;
  } vec_t;

  vec_t tbl[8];
  int   nce, nts;

  initial begin
    // reset 4 clk, run rises, ce toggles, one trigger on the last row
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 48'd0};
    tbl[1] = tbl[0];
    tbl[2] = tbl[0];
    tbl[3] = tbl[0];
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 48'd1};

    for (int i = 0; i < 8; i++) begin
      rst_n = tbl[i].rst_n; run = tbl[i].run; ce = tbl[i].ce; trig = tbl[i].trig;
      tick();
      mchk_en = 1'b1;
      chk("tbl_hold", holdoff_o, tbl[i].e_hold);
      chk("tbl_valid", evt_if.evt_valid, tbl[i].e_valid);
      chk("tbl_dead", dead_o, tbl[i].e_dead);
      chk("tbl_drop", drop_o, tbl[i].e_drop);
      if (tbl[i].e_valid) begin
        chk("tbl_num", evt_if.evt_num, 32'd0);
        chk("tbl_time", evt_if.evt_time, tbl[i].e_tm);
        chk("tbl_meta0", evt_if.evt_meta[63:0], 64'h0123_4567_89AB_CDEF);
      end
    end
    trig = 1'b0;

    // holdoff lasts HL ce cycles; a trigger 4 ce in is dropped
    ce_auto = 1'b1; ce = 1'b1; nce = 0;
    for (int g = 0; g < 200 && holdoff_o; g++) begin
      trig = ce && (nce == 4);
      if (ce) nce++;
      tick();
    end
    trig = 1'b0;
    chk("holdoff_ce_len", nce, HL);
    chk("drop_in_holdoff", drop_o, 1'b1);
    chk("one_entry_num", evt_if.evt_num, 32'd0);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("no_second_entry", evt_if.evt_valid, 1'b0);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("next_num", evt_if.evt_num, 32'd1);
    chk("next_valid", evt_if.evt_valid, 1'b1);
    ready = 1'b1; tick(); ready = 1'b0;

    // back-pressure: 15 entries make dead, the 16th trigger drops
    restart_run();
    for (int k = 0; k < 16; k++) begin
      wait_armed();
      if (k == 14) chk("dead_at_14", dead_o, 1'b0);
      if (k == 15) chk("dead_at_15", dead_o, 1'b1);
      trig = 1'b1; tick(); trig = 1'b0;
    end
    chk("bp_drop", drop_o, 1'b1);
    chk("bp_dead", dead_o, 1'b1);
    drain(0, 15, 1'b1);

    // push and pop in the same clk at occupancy 14
    restart_run();
    for (int k = 0; k < 14; k++) begin
      wait_armed();
      trig = 1'b1; tick(); trig = 1'b0;
    end
    wait_armed();
    chk("pp_head", evt_if.evt_num, 32'd0);
    trig = 1'b1; ready = 1'b1; tick(); trig = 1'b0; ready = 1'b0;
    chk("pp_dead", dead_o, 1'b0);
    drain(1, 14, 1'b0);

    // run drop mid-holdoff, then restart
    restart_run();
    wait_armed();
    trig = 1'b1; tick(); trig = 1'b0; tick(); tick();
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_hold", holdoff_o, 1'b1);
    end
    chk("idle_keep", evt_if.evt_valid, 1'b1);
`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
    chk("dt_nonzero", deadtime_o != 0, 1'b1);
`endif
    run = 1'b1; tick();
    chk("rerun_hold", holdoff_o, 1'b0);
`ifdef PUEO_TRIG_CAPTURE_DEADTIME_EN
    chk("dt_cleared", deadtime_o, 32'd0);
`endif
    nts = 0;
    for (int i = 0; i < 5; i++) begin
      if (ce) nts++;
      tick();
    end
    trig = 1'b1; tick(); trig = 1'b0;
    chk("old_num", evt_if.evt_num, 32'd0);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("rerun_valid", evt_if.evt_valid, 1'b1);
    chk("rerun_num", evt_if.evt_num, 32'd0);
    chk("rerun_time", evt_if.evt_time, nts);
    ready = 1'b1; tick(); ready = 1'b0;

    // reset with an entry queued discards it
    wait_armed();
    trig = 1'b1; tick(); trig = 1'b0;
    chk("pre_rst_valid", evt_if.evt_valid, 1'b1);
    rst_n = 1'b0; tick();
    chk("rst_valid", evt_if.evt_valid, 1'b0);
    chk("rst_hold", holdoff_o, 1'b1);
    chk("rst_drop", drop_o, 1'b0);
    rst_n = 1'b1; tick();

    // random traffic against the model
    ce_auto = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      ce    = 1'($urandom_range(0, 1));
      trig  = ($urandom_range(0, 4) == 0);
      ready = ((i / 800) % 2 == 0) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
      run   = ($urandom_range(0, 299) != 0);
      m0 = {$urandom, $urandom}; m1 = {$urandom, $urandom};
      m2 = {$urandom, $urandom}; m3 = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pueo_trig_capture.md
Name: pueo_trig_capture

Overview:
- Sits directly downstream of the level-two trigger stage.
- Consumes its master trigger pulse and the four delay-aligned TURFIO metadata words.
- Generates the holdoff and dead feedback that gates further triggers.
- Stamps each accepted trigger with an event number and a timestamp, then buffers it in an event FIFO. The event builder drains the FIFO over a valid/ready handshake.

Parameters:
- HOLDOFF_LEN, 16: number of ce_i-qualified cycles holdoff_o stays high after an accepted trigger. Range 1..65535.
- FIFO_AW, 4: FIFO address width. Depth = 2^FIFO_AW entries.
- TS_W, 48: timestamp counter width.

Ports:
- clk_i  in  1  system clock. Same domain as the level-two stage.
- rst_n_i  in  1  synchronous, active-low reset.
- ce_i  in  1  sysclk_x2 clock enable. Same ce that the level-two stage uses.
- run_i  in  1  run enable. Its rising edge clears the counters.
- trig_i  in  1  master trigger pulse from level two. One clk wide.
- tio0_meta_i … tio3_meta_i  in  64 each  metadata, valid in the same cycle as trig_i.
- holdoff_o  out  1  to level two: trigger holdoff.
- dead_o  out  1  to level two: FIFO cannot absorb another event.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts the event.
- evt_num_o  out  32  event number.
- evt_time_o  out  TS_W  timestamp.
- evt_meta_o  out  256  {tio3,tio2,tio1,tio0} metadata.
- drop_o  out  1  sticky: a trigger arrived while holdoff or dead was set. Cleared by reset or by a run_i rising edge.

Behaviour:
- Reset, while rst_n_i is 0 on a clock edge:
  - holdoff_o=1, dead_o=0, evt_valid_o=0, drop_o=0.
  - FIFO flushed; event counter and timestamp counter = 0.
  - State = IDLE.
  - A reset asserted mid-event discards all queued entries with no partial output.
- Timestamp:
  - Increments by 1 on each ce_i while state is not IDLE.
  - Wraps modulo 2^TS_W with no flag.
- Event number:
  - 32-bit. Increments on every accepted trigger and wraps at 2^32-1 to 0.
  - The first event of a run carries number 0.
- State machine, IDLE / ARMED / HOLDOFF:
  - IDLE: holdoff_o=1. On the run_i rising edge: clear timestamp, event number and drop_o, then go to ARMED.
  - ARMED: holdoff_o=0.
    - trig_i=1 with dead_o=0 means accept. Push {num, time, meta} into the FIFO, load the holdoff counter with HOLDOFF_LEN, go to HOLDOFF.
    - trig_i=1 with dead_o=1 means no push and drop_o set; the holdoff is still entered.
  - HOLDOFF: holdoff_o=1.
    - The counter decrements on ce_i. At 0, go to ARMED.
    - trig_i=1 in this state: no push, drop_o set.
  - run_i=0 in any state: go to IDLE on the next clock. FIFO contents remain drainable.
- Holdoff timing:
  - holdoff_o is registered and rises the clk after the accepting trig_i.
  - The level-two stage therefore sees it at its next ce.
- dead_o:
  - Registered. It is 1 when FIFO occupancy ≥ 2^FIFO_AW − 1.
  - This leaves one slot for a trigger already in flight.
- FIFO push/pop:
  - A pop happens when evt_valid_o && evt_ready_i.
  - First-word fall-through: outputs are valid whenever evt_valid_o=1 and stay stable while evt_ready_i=0.
  - Push and pop in the same cycle leave occupancy unchanged, including when the FIFO is full.
  - A push into a truly full FIFO cannot occur, because accept requires dead_o=0.
- Latency: trig_i accepted at clk t gives evt_valid_o=1 at t+1 when the FIFO was empty.

Optional Feature:
- Macro: PUEO_TRIG_CAPTURE_DEADTIME_EN.
- Defined:
  - Adds output deadtime_o, 32 bits.
  - It counts ce_i cycles in which (holdoff_o || dead_o) is set while state is not IDLE.
  - It saturates at 0xFFFFFFFF and clears on the run_i rising edge or reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then run: hold rst_n_i=0 for 4 clk, release, raise run_i, ce_i toggling every other clk. Required: holdoff_o falls within 2 clk; evt_valid_o=0; timestamp advances by 1 per ce.
- Single trigger: one trig_i pulse with tio0_meta_i=64'h0123_4567_89AB_CDEF, others 0. Required:
  - at t+1, evt_valid_o=1, evt_num_o=0, evt_meta_o[63:0]=64'h0123_4567_89AB_CDEF;
  - holdoff_o high for exactly 16 ce cycles, then low.
- Trigger during holdoff: a second trig_i 4 ce after the first. Required: no second FIFO entry; drop_o=1; event number for the next accepted trigger = 1.
- Back-pressure: evt_ready_i=0, FIFO_AW=4, HOLDOFF_LEN=1, with 16 triggers spaced past holdoff. Required:
  - dead_o=1 after 15 entries;
  - the 16th trigger is dropped with drop_o=1;
  - then evt_ready_i=1 drains events 0..14 in order, and dead_o deasserts after the first pop.
- Simultaneous push/pop at occupancy 14: accept and pop in the same clk. Required: occupancy stays 14; no entry is lost or duplicated.
- run_i drop mid-holdoff: holdoff_o stays 1; queued events remain drainable; the run_i rising edge restarts the event number at 0 and the timestamp at 0. With PUEO_TRIG_CAPTURE_DEADTIME_EN defined, deadtime_o is also cleared to 0.
